digit_scan_ctrl: RTL

//  Time-multiplexed 2-digit 7-segment scan controller feeding the 2-to-4 digit-enable encoder.

---
 rtl/digit_scan_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/digit_scan_ctrl.sv
// Purpose     : 2-digit time-multiplexed 7-segment scan (SHOW0, BLANK0, SHOW1, BLANK1) with a frame-synchronous update buffer.
// Latency     : an accepted update is displayed from the next BLANK1->SHOW0 edge; outputs decode registered state only.
// Backpressure: upd_rdy is low while the single-entry pending buffer is full; it frees on the frame commit.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   en                    scan enable; low parks the scan in a blanked BLANK1
//   upd_vld/upd_rdy       update handshake carrying upd_d0/upd_d1 (hex nibbles)
//   digit_sel             2'b00 digit 0, 2'b01 digit 1, 2'b10 encoder all-off
//   seg                   active-low {g,f,e,d,c,b,a}, 7'h7F = dark
//   frame_stb             single-cycle pulse in the first SHOW0 cycle of each frame
module digit_scan_ctrl #(
    parameter int DWELL_CYC = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       upd_vld,
    output logic       upd_rdy,
    input  logic [3:0] upd_d0,
    input  logic [3:0] upd_d1,
    output logic [1:0] digit_sel,
    output logic [6:0] seg,
    output logic       frame_stb
);

    localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    logic [3:0]    shown_d0, shown_d1;
    logic [3:0]    pend_d0, pend_d1;
    logic          pend_full;
    logic          accept;
    logic          commit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Last cycle of the current state; SHOW states use the dwell length.
    assign last = (state_q == SHOW0 || state_q == SHOW1) ? (cnt_q == DWELL_LAST)
                                                         : (cnt_q == BLANK_LAST);

    // Commit only when the scan really crosses the frame boundary, so a
    // disabled display never swaps in pending data.
    assign commit  = en && (state_q == BLANK1) && last && pend_full;
    assign upd_rdy = ~pend_full;
    assign accept  = upd_vld && upd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        digit_sel = 2'b10;
        seg       = 7'h7F;
        frame_stb = 1'b0;

        if (!en) begin
            // Park in BLANK1 so re-enable gives a full blanking gap before SHOW0.
            state_d = BLANK1;
            cnt_d   = '0;
        end else if (last) begin
            cnt_d = '0;
            case (state_q)
                SHOW0:   state_d = BLANK0;
                BLANK0:  state_d = SHOW1;
                SHOW1:   state_d = BLANK1;
                default: state_d = SHOW0;
            endcase
        end

        case (state_q)
            SHOW0: begin
                digit_sel = 2'b00;
                seg       = hex7(shown_d0);
                frame_stb = (cnt_q == '0);
            end
            SHOW1: begin
                digit_sel = 2'b01;
                seg       = hex7(shown_d1);
            end
            default: begin
                digit_sel = 2'b10;
                seg       = 7'h7F;
            end
        endcase
    end

    // Accept and commit are mutually exclusive (accept needs an empty buffer,
    // commit a full one), so an accept on the boundary edge lands in pending
    // and is shown one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend_d0   <= '0;
            pend_d1   <= '0;
            shown_d0  <= '0;
            shown_d1  <= '0;
        end else begin
            if (accept) begin
                pend_d0   <= upd_d0;
                pend_d1   <= upd_d1;
                pend_full <= 1'b1;
            end else if (commit) begin
                pend_full <= 1'b0;
            end
            if (commit) begin
                shown_d0 <= pend_d0;
                shown_d1 <= pend_d1;
            end
        end
    end

endmodule
